// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide execute unit: op codes,
// FSM state encoding and the decoder's opcode/funct7 match values.
package muldiv_pkg;

   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   function automatic logic is_div_op(input logic [2:0] f);
      return f[2];
   endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: sign detection, magnitudes, and the
// division special cases (divide by zero, signed overflow) with their results.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            sign_a,
   output logic            sign_b,
   output logic [XLEN-1:0] mag_a,
   output logic [XLEN-1:0] mag_b,
   output logic            special,
   output logic [XLEN-1:0] special_result
);

   logic a_signed;
   logic b_signed;
   logic div_zero;
   logic div_ovf;

   always_comb begin
      a_signed = funct3 inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
      b_signed = funct3 inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
      sign_a   = a_signed & op_a[XLEN-1];
      sign_b   = b_signed & op_b[XLEN-1];
      mag_a    = sign_a ? -op_a : op_a;
      mag_b    = sign_b ? -op_b : op_b;

      div_zero = is_div_op(funct3) && (op_b == '0);
      div_ovf  = (funct3 inside {MD_DIV, MD_REM}) &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      special  = div_zero | div_ovf;

      // funct3[1] distinguishes REM/REMU from DIV/DIVU
      special_result = '0;
      if (div_zero)
         special_result = funct3[1] ? op_a : '1;
      else if (div_ovf)
         special_result = funct3[1] ? '0 : op_a;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Optional build macro
// MULDIV_FAST_MUL_EN makes the multiply ops single-cycle combinational.
//
// state   | meaning
// IDLE    | waiting for start; latches operands
// CALC    | one shift-add / shift-subtract iteration per cycle
// DONE    | final sign fix-up; result and done registered on exit
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_dout,
   input  logic [XLEN-1:0] rs2_dout,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   md_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op_r;
   logic              sign_a_r, sign_b_r;
   logic [XLEN-1:0]   opnd_r;
   logic [2*XLEN-1:0] acc, step_acc;
   logic              spec_r;
   logic [XLEN-1:0]   spec_res_r;
   logic              done_r;
   logic [XLEN-1:0]   result_r;

   logic              sign_a, sign_b, special;
   logic [XLEN-1:0]   mag_a, mag_b, special_result;

   logic [XLEN:0]     add_sum, sub_diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, final_res;
   logic              accept;

   muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
      .funct3         (funct3),
      .op_a           (rs1_dout),
      .op_b           (rs2_dout),
      .sign_a         (sign_a),
      .sign_b         (sign_b),
      .mag_a          (mag_a),
      .mag_b          (mag_b),
      .special        (special),
      .special_result (special_result)
   );

   assign accept = start & ~kill;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (special)
                  state_nxt = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div_op(funct3))
                  state_nxt = ST_DONE;
`endif
               else
                  state_nxt = ST_CALC;
            end
         end
         ST_CALC: begin
            if (kill)
               state_nxt = ST_IDLE;
            else if (cnt == CNT_W'(XLEN-1))
               state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // acc holds {hi, lo}: product/multiplier for multiply, {remainder, quotient} for divide
   always_comb begin
      add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_r} : '0);
      sub_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd_r};
      if (is_div_op(op_r))
         step_acc = sub_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         step_acc = {add_sum, acc[XLEN-1:1]};
   end

   always_comb begin
      prod = (sign_a_r ^ sign_b_r) ? -acc : acc;
      quo  = (sign_a_r ^ sign_b_r) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = sign_a_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      final_res = rem;
      if (spec_r)
         final_res = spec_res_r;
      else begin
         case (op_r)
            MD_MUL:                       final_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_res = quo;
            default:                      final_res = rem;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         op_r       <= MD_MUL;
         sign_a_r   <= 1'b0;
         sign_b_r   <= 1'b0;
         opnd_r     <= '0;
         acc        <= '0;
         spec_r     <= 1'b0;
         spec_res_r <= '0;
         done_r     <= 1'b0;
         result_r   <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_r       <= funct3;
                  sign_a_r   <= sign_a;
                  sign_b_r   <= sign_b;
                  opnd_r     <= mag_b;
                  acc        <= {{XLEN{1'b0}}, mag_a};
                  spec_r     <= special;
                  spec_res_r <= special_result;
                  cnt        <= '0;
`ifdef MULDIV_FAST_MUL_EN
                  if (!is_div_op(funct3))
                     acc <= (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`endif
               end
            end
            ST_CALC: begin
               if (!kill) begin
                  acc <= step_acc;
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (!kill) begin
                  done_r   <= 1'b1;
                  result_r <= final_res;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state != ST_IDLE);
   assign done   = done_r;
   assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, start/kill/reset
// corner cases, then random operations against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_dout;
   logic [31:0] rs2_dout;
   logic        kill;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_result;

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .funct3   (funct3),
      .rs1_dout (rs1_dout),
      .rs2_dout (rs2_dout),
      .kill     (kill),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (f)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
      if (f >= 3'd4 && b == 0) return 2;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
      if (f < 3'd4) return 2;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 200));
         default: return $urandom;
      endcase
   endfunction

   // Launch one op and follow it to done; latency counts edges from the accepting edge.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int lat;
      bit seen;
      bit busy_ok;
      logic [31:0] exp;
      exp = model(f, a, b);
      @(negedge clk);
      funct3 = f; rs1_dout = a; rs2_dout = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      seen = 1'b0;
      busy_ok = busy;
      while (!seen && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (done) seen = 1'b1;
         else if (!busy) busy_ok = 1'b0;
      end
      chk({tag, " result"}, result, exp);
      chk({tag, " latency"}, 32'(lat), 32'(model_lat(f, a, b)));
      chk({tag, " busy"}, {31'b0, busy_ok}, 32'h1);
      @(posedge clk); #1;
      chk({tag, " done pulse"}, {31'b0, done}, 32'h0);
      last_result = exp;
   endtask

   initial begin
      int ndone;
      int done_lat;
      logic [31:0] r;
      logic [31:0] exp;

      reset = 1'b0; start = 1'b0; kill = 1'b0;
      funct3 = 3'd0; rs1_dout = '0; rs2_dout = '0;
      last_result = '0;
      #3;
      chk("reset busy", {31'b0, busy}, 32'h0);
      chk("reset done", {31'b0, done}, 32'h0);
      chk("reset result", result, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "MUL 7*-3");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH");
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
      run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, "DIV -7/2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, "REM -7/2");
      run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
      run_op(3'd7, 32'd100, 32'd7, "REMU 100/7");
      run_op(3'd5, 32'd5, 32'd0, "DIVU 5/0");
      run_op(3'd6, 32'd5, 32'd0, "REM 5/0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");

      // second start during a multiply must be ignored
      exp = model(3'd0, 32'd12345, 32'd678);
      @(negedge clk);
      funct3 = 3'd0; rs1_dout = 32'd12345; rs2_dout = 32'd678; start = 1'b1;
      @(posedge clk); #1;
      ndone = 0; done_lat = 0; r = '0;
      for (int c = 2; c <= 45; c++) begin
         @(negedge clk);
         start = (c == 11);
         funct3 = (c == 11) ? 3'd5 : 3'd0;
         rs2_dout = (c == 11) ? 32'd0 : 32'd678;
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (done_lat == 0) done_lat = c;
            r = result;
         end
      end
      start = 1'b0;
      chk("restart done count", 32'(ndone), 32'd1);
      chk("restart latency", 32'(done_lat), 32'(model_lat(3'd0, 32'd12345, 32'd678)));
      chk("restart result", r, exp);
      last_result = exp;

      // kill mid-calculation
      @(negedge clk);
      funct3 = 3'd5; rs1_dout = 32'd999; rs2_dout = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill busy", {31'b0, busy}, 32'h0);
      chk("kill done", {31'b0, done}, 32'h0);
      chk("kill result", result, last_result);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("kill no done", 32'(ndone), 32'd0);

      // kill in IDLE blocks a simultaneous start
      @(negedge clk);
      funct3 = 3'd4; rs1_dout = 32'd7; rs2_dout = 32'd0; start = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      chk("idle kill busy", {31'b0, busy}, 32'h0);
      ndone = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("idle kill no done", 32'(ndone), 32'd0);
      chk("idle kill result", result, last_result);

      // asynchronous reset between edges during CALC
      @(negedge clk);
      funct3 = 3'd0; rs1_dout = 32'hDEAD_BEEF; rs2_dout = 32'h1234_5678; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk("async rst busy", {31'b0, busy}, 32'h0);
      chk("async rst done", {31'b0, done}, 32'h0);
      chk("async rst result", result, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, "post-reset MULH");

      for (int i = 0; i < 40; i++) begin
         logic [2:0] f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = rand_operand();
         b = rand_operand();
         run_op(f, a, b, $sformatf("rand%0d f%0d %h %h", i, f, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
